// File: rtl/mul_seq_trunc.sv
// Sequential shift-add signed multiplier, one multiplier bit per cycle.
// Approximate mode drops the low TRUNC product columns from every partial product.
module mul_seq_trunc #(
    parameter int W     = 8,
    parameter int TRUNC = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           approx_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] o,
    output logic           busy
);

    localparam int PW = 2 * W;
    localparam int JW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [PW-1:0] ONE    = PW'(1);
    localparam logic [PW-1:0] TMASK  = ~((ONE << TRUNC) - ONE);
    localparam logic [JW-1:0] J_LAST = JW'(W - 1);

    logic [1:0]    state_q,  state_d;
    logic [W-1:0]  a_q,      a_d;
    logic [W-1:0]  b_q,      b_d;
    logic          approx_q, approx_d;
    logic [PW-1:0] acc_q,    acc_d;
    logic [JW-1:0] j_q,      j_d;

    logic [PW-1:0] sext_a;
    logic [PW-1:0] col_mask;
    logic [PW-1:0] addend;
    logic          last_step;

    assign sext_a    = {{W{a_q[W-1]}}, a_q};
    assign col_mask  = approx_q ? TMASK : '1;
    assign addend    = (sext_a << j_q) & col_mask;
    assign last_step = (j_q == J_LAST);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        approx_d = approx_q;
        acc_d    = acc_q;
        j_d      = j_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    approx_d = approx_en;
                    acc_d    = '0;
                    j_d      = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // MSB of the multiplier carries negative weight in two's complement
                if (b_q[j_q]) begin
                    if (last_step) acc_d = acc_q - addend;
                    else           acc_d = acc_q + addend;
                end
                if (last_step) state_d = S_DONE;
                else           j_d     = j_q + JW'(1);
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            approx_q <= 1'b0;
            acc_q    <= '0;
            j_q      <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            approx_q <= approx_d;
            acc_q    <= acc_d;
            j_q      <= j_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign o         = out_valid ? acc_q : '0;

endmodule

// File: tb/tb_mul_seq_trunc.sv
// Self-checking bench: three instances (TRUNC = 0, 4, 15) driven in lockstep and
// compared against an arithmetic model of the truncated partial-product sum.
module tb_mul_seq_trunc;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          approx_en;
    logic          out_ready;

    logic          rdy0, rdy4, rdy15;
    logic          ov0, ov4, ov15;
    logic          busy0, busy4, busy15;
    logic [PW-1:0] o0, o4, o15;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_seq_trunc #(.W(W), .TRUNC(0)) u_t0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
        .approx_en(approx_en), .out_valid(ov0), .out_ready(out_ready), .o(o0), .busy(busy0)
    );
    mul_seq_trunc #(.W(W), .TRUNC(4)) u_t4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .a(a), .b(b),
        .approx_en(approx_en), .out_valid(ov4), .out_ready(out_ready), .o(o4), .busy(busy4)
    );
    mul_seq_trunc #(.W(W), .TRUNC(15)) u_t15 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy15), .a(a), .b(b),
        .approx_en(approx_en), .out_valid(ov15), .out_ready(out_ready), .o(o15), .busy(busy15)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] exact_prod(input logic [W-1:0] av, input logic [W-1:0] bv);
        longint p;
        p = longint'($signed(av)) * longint'($signed(bv));
        return p[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] ref_model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                                input logic ap, input int trunc);
        longint sa, m, acc;
        sa  = longint'($signed(av));
        m   = ap ? ~((longint'(1) << trunc) - longint'(1)) : -longint'(1);
        acc = 0;
        for (int j = 0; j < W; j++) begin
            if (bv[j]) begin
                if (j == W - 1) acc = acc - ((sa <<< j) & m);
                else            acc = acc + ((sa <<< j) & m);
            end
        end
        return acc[PW-1:0];
    endfunction

    int first_acc = 0;
    int last_acc  = 0;

    // One full transaction with out_ready high; noisy=1 scrambles inputs while in flight.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ap,
                         input bit noisy, output logic [PW-1:0] got4);
        int n;
        logic [PW-1:0] e0, e4, e15;
        e0  = exact_prod(av, bv);
        e4  = ref_model(av, bv, ap, 4);
        e15 = ref_model(av, bv, ap, 15);
        a = av; b = bv; approx_en = ap; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!rdy4 && n < 40) begin tick(); n++; end
        chk("in_ready_at_offer", 64'(rdy4), 64'(1));
        last_acc = cyc;
        tick();
        in_valid = 1'b0;
        if (noisy) begin
            a = W'($urandom); b = W'($urandom); approx_en = 1'($urandom); in_valid = 1'($urandom);
        end
        n = 1;
        while (!ov4 && n < 40) begin
            tick();
            n++;
            if (noisy) begin
                a = W'($urandom); b = W'($urandom); approx_en = 1'($urandom); in_valid = 1'($urandom);
            end
        end
        chk("latency_cycles", 64'(n), 64'(W + 1));
        chk("o_trunc4", 64'(o4), 64'(e4));
        chk("o_trunc0", 64'(o0), 64'(e0));
        chk("o_trunc15", 64'(o15), 64'(e15));
        chk("out_valid_others", 64'({ov0, ov15}), 64'(2'b11));
        got4 = o4;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PW-1:0] got;
        int n;
        bit saw_ov;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; approx_en = 1'b0; out_ready = 1'b0;
        #1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'({rdy0, rdy4, rdy15}), 64'(3'b111));
        chk("rst_out_valid", 64'({ov0, ov4, ov15}), 64'(0));
        chk("rst_busy", 64'({busy0, busy4, busy15}), 64'(0));
        chk("rst_o", 64'({o0, o4, o15}), 64'(0));

        do_op(8'h80, 8'h80, 1'b0, 1'b0, got); chk("dir_80x80_exact", 64'(got), 64'(16'h4000));
        do_op(8'h7F, 8'h7F, 1'b0, 1'b0, got); chk("dir_7Fx7F_exact", 64'(got), 64'(16'h3F01));
        do_op(8'h7F, 8'h7F, 1'b1, 1'b0, got); chk("dir_7Fx7F_approx", 64'(got), 64'(16'h3ED0));
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, got); chk("dir_FFx01_exact", 64'(got), 64'(16'hFFFF));
        do_op(8'hFF, 8'h01, 1'b1, 1'b0, got); chk("dir_FFx01_approx", 64'(got), 64'(16'hFFF0));

        // Stall in DONE while offering new operands.
        a = 8'h7F; b = 8'h7F; approx_en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!ov4 && n < 40) begin tick(); n++; end
        chk("hold_latency", 64'(n), 64'(W + 1));
        for (int k = 0; k < 5; k++) begin
            a = W'($urandom); b = W'($urandom); approx_en = 1'b0; in_valid = 1'b1;
            chk("hold_o", 64'(o4), 64'(16'h3ED0));
            chk("hold_out_valid", 64'(ov4), 64'(1));
            chk("hold_in_ready", 64'(rdy4), 64'(0));
            tick();
        end
        chk("hold_o_end", 64'(o4), 64'(16'h3ED0));
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("hold_release_ov", 64'(ov4), 64'(0));
        chk("hold_release_busy", 64'(busy4), 64'(0));
        chk("hold_release_o", 64'(o4), 64'(0));

        // Reset on the third RUN cycle.
        a = 8'h55; b = 8'h33; approx_en = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_rst_in_ready", 64'(rdy4), 64'(1));
        chk("midrun_rst_busy", 64'(busy4), 64'(0));
        chk("midrun_rst_ov", 64'(ov4), 64'(0));
        chk("midrun_rst_o", 64'(o4), 64'(0));
        saw_ov = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (ov0 || ov4 || ov15) saw_ov = 1'b1;
            tick();
        end
        chk("midrun_rst_no_pulse", 64'(saw_ov), 64'(0));
        do_op(8'h7F, 8'h7F, 1'b0, 1'b0, got); chk("after_rst_exact", 64'(got), 64'(16'h3F01));

        // Reset while holding a result, then reset colliding with an offer.
        a = 8'h12; b = 8'h34; approx_en = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!ov4 && n < 40) begin tick(); n++; end
        chk("done_reached", 64'(ov4), 64'(1));
        rst = 1'b1;
        tick();
        chk("done_rst_ov", 64'(ov4), 64'(0));
        in_valid = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_beats_accept", 64'(busy4), 64'(0));
        out_ready = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, got);
            if (i == 0) first_acc = last_acc;
        end
        chk("throughput", 64'(last_acc - first_acc), 64'(999 * (W + 2)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_seq_trunc.md
MUL_SEQ_TRUNC -- requirements
Module: mul_seq_trunc

Interface
- REQ-001: Parameter W, default 8, is the operand width in bits; legal range 2..32.
- REQ-002: Parameter TRUNC, default 4, is the number of low product columns dropped in approximate mode; legal range 0..2W-1.
- REQ-003: Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
- REQ-004: Port rst, input, 1 bit, is the reset; it is synchronous and active-high.
- REQ-005: Port in_valid, input, 1 bit, means an operand pair is offered.
- REQ-006: Port in_ready, output, 1 bit, means the block accepts an operand pair this cycle.
- REQ-007: Port a, input, W bits, is the two's-complement multiplicand.
- REQ-008: Port b, input, W bits, is the two's-complement multiplier.
- REQ-009: Port approx_en, input, 1 bit, selects approximate (1) or exact (0) mode for the offered pair.
- REQ-010: Port out_valid, output, 1 bit, means o holds a finished product.
- REQ-011: Port out_ready, input, 1 bit, means the consumer takes o this cycle.
- REQ-012: Port o, output, 2W bits, is the two's-complement product.
- REQ-013: Port busy, output, 1 bit, is high whenever the FSM is not in IDLE.

Function
- REQ-014: The FSM SHALL have exactly three states: IDLE, RUN and DONE.
- REQ-015: in_ready SHALL be 1 only in IDLE, and it SHALL not depend combinationally on in_valid.
- REQ-016: Accept occurs on an edge where in_valid=1 and in_ready=1; a, b and approx_en SHALL be registered, the accumulator cleared, the step counter j set to 0, and the FSM moved IDLE->RUN.
- REQ-017: In RUN, each cycle SHALL process multiplier bit j: addend = (sext2W(A) << j) masked with the column mask M, where M = ~(2^TRUNC - 1) if approx and M = all ones otherwise.
- REQ-018: For j < W-1 the addend SHALL be added when b_j=1; for j = W-1 it SHALL be subtracted when b_j=1 (sign weight); all arithmetic is modulo 2^(2W).
- REQ-019: After the step with j = W-1 the FSM SHALL go RUN->DONE; RUN therefore lasts exactly W cycles.
- REQ-020: In DONE, out_valid SHALL be 1 and o SHALL equal the accumulator; o SHALL be 0 in IDLE and RUN.
- REQ-021: The reference model is o = sum_j s_j * b_j * ((sext(a) << j) & M) mod 2^(2W), with s_j = -1 for j = W-1 and +1 otherwise.
- REQ-022: With approx_en=0 the result SHALL be the exact signed product; with approx_en=1 the low TRUNC bits of o SHALL be 0.
- REQ-023: Latency: out_valid SHALL rise W+1 cycles after the accept edge.
- REQ-024: DONE SHALL hold o and out_valid stable until out_valid=1 and out_ready=1, then go to IDLE; maximum throughput is one product per W+2 cycles.
- REQ-025: in_valid SHALL be ignored outside IDLE; a change on approx_en, a or b after accept SHALL not affect the result in flight.
- REQ-026: With TRUNC=0, approximate mode SHALL equal exact mode.

Reset
- REQ-027: When rst=1 at an edge, the FSM SHALL go to IDLE and the accumulator, j and the registered operands SHALL clear, in any state.
- REQ-028: After reset: in_ready=1, out_valid=0, busy=0, o=0.
- REQ-029: A reset during RUN or DONE SHALL discard the operation with no out_valid pulse; rst has priority over an accept in the same cycle.

Verification (W=8, TRUNC=4)
- REQ-030: a=0x80, b=0x80, approx_en=0 -> o=0x4000 with out_valid exactly 9 cycles after accept.
- REQ-031: a=0x7F, b=0x7F -> exact o=0x3F01; approx o=0x3ED0 (error 49).
- REQ-032: a=0xFF, b=0x01 -> exact o=0xFFFF; approx o=0xFFF0.
- REQ-033: Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> o and out_valid stable, in_ready=0, new operands not accepted.
- REQ-034: Assert rst on the 3rd RUN cycle -> next cycle: in_ready=1, busy=0, out_valid=0, o=0; the next accepted pair computes correctly.
- REQ-035: 1000 random pairs with random approx_en, out_ready held at 1, and TRUNC in {0,4,15} -> each o matches the REQ-021 model, at one result per 10 cycles.
